burst_fifo: RTL

- Parametrised single-clock FIFO with a registered output stage and ready/valid handshakes on both sides.
- Generalises the fixed 16x8 fill-then-drain buffer in width, depth and drain threshold.
- Two operating modes: STREAM (read whenever data is present) and BURST (hold output until a threshold fills, then drain to empty).
- Sits between a producer and a consumer in the same clock domain; status flags feed control FSMs upstream.

---
 rtl/burst_fifo_pkg.sv | 18 +
 rtl/fifo_mem_2p.sv | 27 ++
 rtl/burst_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/burst_fifo_pkg.sv
// burst_fifo_pkg: shared constants, FSM encoding and width helper
// for the burst_fifo slice.
package burst_fifo_pkg;

  localparam int MODE_STREAM = 0;
  localparam int MODE_BURST  = 1;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // count must hold 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: WIDTH x DEPTH register array, one write port and
// one combinational read port, no reset.
// Ports: clk; we_i/waddr_i/wdata_i write; raddr_i/rdata_o read.
module fifo_mem_2p #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/burst_fifo.sv
// burst_fifo: single-clock FIFO with registered output stage and
// STREAM / BURST (fill to BURST_LEN, then drain to empty) modes.
// Ports: clk, rst_n (async, active low), flush (sync clear, keeps
//   overflow); wr_en/wr_data/wr_ready producer side; rd_data/
//   rd_valid/rd_ready consumer side; count/empty/full/almost_full
//   status; overflow sticky until rst_n.
module burst_fifo
  import burst_fifo_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 8,
  parameter int BURST_MODE = MODE_STREAM,
  parameter int BURST_LEN  = DEPTH,
  parameter int AF_LEVEL   = DEPTH - 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    wr_ready,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] BLEN_C  = CW'(BURST_LEN);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PINC_C  = AW'(1);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovld_q, ovld_d;
  logic [WIDTH-1:0] rdat_q, rdat_d;
  logic             rvld_q, rvld_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;

  logic [WIDTH-1:0] mem_rdata;
  logic [CW-1:0]    mem_cnt;
  logic             wr_fire;
  logic             rd_fire;
  logic             load;
  logic             full_w;

  assign full_w  = (count_q == DEPTH_C);
  assign wr_fire = wr_en && !full_w;
  assign rd_fire = rvld_q && rd_ready;

  // words still in the array, i.e. not yet in the output stage
  assign mem_cnt = count_q - {{(CW-1){1'b0}}, ovld_q};

  // refill the stage when it is free or being consumed now
  assign load = (mem_cnt != '0) && (!ovld_q || rd_fire);

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_fire && !flush),
    .waddr_i (wptr_q),
    .wdata_i (wr_data),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovld_d  = ovld_q;
    rdat_d  = rdat_q;
    ovf_d   = ovf_q | (wr_en & full_w);
    state_d = state_q;

    if (wr_fire) begin
      wptr_d = wptr_q + PINC_C;
    end

    if (load) begin
      rptr_d = rptr_q + PINC_C;
      rdat_d = mem_rdata;
      ovld_d = 1'b1;
    end else if (rd_fire) begin
      ovld_d = 1'b0;
    end

    unique case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      ST_FILL: begin
        if (count_d >= BLEN_C) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rd_fire && (count_d == '0)) begin
          state_d = ST_FILL;
        end
      end
    endcase

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovld_d  = 1'b0;
      rdat_d  = '0;
      ovf_d   = ovf_q;
      state_d = ST_FILL;
    end

    rvld_d = ovld_d &&
             ((BURST_MODE == MODE_STREAM) ||
              (state_d == ST_DRAIN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovld_q  <= 1'b0;
      rdat_q  <= '0;
      rvld_q  <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= ST_FILL;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovld_q  <= ovld_d;
      rdat_q  <= rdat_d;
      rvld_q  <= rvld_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign rd_data     = rdat_q;
  assign rd_valid    = rvld_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign full        = full_w;
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AF_C);
  assign wr_ready    = !full_w;

endmodule
